dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_starve_cnt.sv | 35 +++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding, default widths
// and the starvation-counter width helper.
package dmem_pkg;

    localparam int DMEM_ADDR_W       = 8;
    localparam int DMEM_DATA_W       = 64;
    localparam int DMEM_STARVE_LIMIT = 4;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    // Bits needed to count from 0 up to and including the limit.
    function automatic int starve_cnt_w(input int limit);
        if (limit < 1) begin
            return 1;
        end else begin
            return $clog2(limit + 1);
        end
    endfunction

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating DMA starvation counter: counts consecutive denied DMA cycles and
// raises force_dma once the limit is reached.
module dmem_starve_cnt
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    localparam int              CNT_W   = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_r;

    // Count denied DMA cycles; any grant or a dropped request restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!dma_req || dma_gnt) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != LIMIT_C) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign force_dma = (cnt_r == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port data memory with a
// combinational read path. Optional DMA anti-starvation via DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wea,
    input  logic [DATA_W-1:0] mem_dout
);

    owner_e            owner_r;
    logic              rd_pend_r;
    logic [ADDR_W-1:0] addr_hold_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] dma_rdata_r;

    logic              force_dma_s;
    logic              cpu_gnt_s;
    logic              dma_gnt_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              mem_wea_s;

`ifdef DMEM_ARB_STARVE_EN
    dmem_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk       (clk),
        .rst       (rst),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt_s),
        .force_dma (force_dma_s)
    );
`else
    logic [31:0] unused_limit_s;
    assign unused_limit_s = 32'(STARVE_LIMIT);
    assign force_dma_s    = 1'b0;
`endif

    // Grant selection: CPU first unless the DMA has waited out its limit.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dma_gnt_s = 1'b0;
        if (rst) begin
            cpu_gnt_s = 1'b0;
            dma_gnt_s = 1'b0;
        end else if (force_dma_s && dma_req) begin
            dma_gnt_s = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else if (dma_req) begin
            dma_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            dma_gnt_s = 1'b0;
        end
    end

    // Memory-side mux; with no grant the address parks on the last granted one.
    always_comb begin
        mem_addr_s  = addr_hold_r;
        mem_wdata_s = {DATA_W{1'b0}};
        mem_wea_s   = 1'b0;
        if (cpu_gnt_s) begin
            mem_addr_s  = cpu_addr;
            mem_wdata_s = cpu_wdata;
            mem_wea_s   = cpu_we;
        end else if (dma_gnt_s) begin
            mem_addr_s  = dma_addr;
            mem_wdata_s = dma_wdata;
            mem_wea_s   = dma_we;
        end else begin
            mem_addr_s  = addr_hold_r;
            mem_wdata_s = {DATA_W{1'b0}};
            mem_wea_s   = 1'b0;
        end
    end

    // Owner FSM: follows the most recent grant, selects which port gets rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r <= OWN_CPU;
        end else begin
            case (owner_r)
                OWN_CPU: if (dma_gnt_s) owner_r <= OWN_DMA;
                OWN_DMA: if (cpu_gnt_s) owner_r <= OWN_CPU;
                default: owner_r <= OWN_CPU;
            endcase
        end
    end

    // Read capture, pending-read flag and parked address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_r   <= 1'b0;
            addr_hold_r <= {ADDR_W{1'b0}};
            cpu_rdata_r <= {DATA_W{1'b0}};
            dma_rdata_r <= {DATA_W{1'b0}};
        end else if (cpu_gnt_s) begin
            rd_pend_r   <= ~cpu_we;
            addr_hold_r <= cpu_addr;
            if (!cpu_we) begin
                cpu_rdata_r <= mem_dout;
            end
        end else if (dma_gnt_s) begin
            rd_pend_r   <= ~dma_we;
            addr_hold_r <= dma_addr;
            if (!dma_we) begin
                dma_rdata_r <= mem_dout;
            end
        end else begin
            rd_pend_r <= 1'b0;
        end
    end

    assign cpu_gnt    = cpu_gnt_s;
    assign dma_gnt    = dma_gnt_s;
    assign cpu_rvalid = rd_pend_r && (owner_r == OWN_CPU);
    assign dma_rvalid = rd_pend_r && (owner_r == OWN_DMA);
    assign cpu_rdata  = cpu_rdata_r;
    assign dma_rdata  = dma_rdata_r;
    assign mem_raddr  = mem_addr_s;
    assign mem_waddr  = mem_addr_s;
    assign mem_wdata  = mem_wdata_s;
    assign mem_wea    = mem_wea_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus hand-written reset and
// starvation sequences, read data checked through a scoreboard queue.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0]  cpu_addr, dma_addr;
    logic [63:0] cpu_wdata, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [63:0] cpu_rdata, dma_rdata;
    logic [7:0]  mem_raddr, mem_waddr;
    logic [63:0] mem_wdata, mem_dout;
    logic        mem_wea;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wea(mem_wea), .mem_dout(mem_dout)
    );

    function automatic logic [63:0] pat(input logic [7:0] a);
        return {24'hC0FFEE, a, 24'h5A5A5A, ~a};
    endfunction

    // Data memory: unwritten locations read back a fixed pattern.
    logic [63:0] mem     [256];
    logic        mem_vld [256];
    logic        mem_clr;
    assign mem_dout = mem_vld[mem_raddr] ? mem[mem_raddr] : pat(mem_raddr);
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_vld[i] <= 1'b0;
        end else if (mem_wea) begin
            mem[mem_waddr]     <= mem_wdata;
            mem_vld[mem_waddr] <= 1'b1;
        end
    end

    typedef struct {
        logic        cr, cw;
        logic [7:0]  ca;
        logic [63:0] cd;
        logic        dr, dw;
        logic [7:0]  da;
        logic [63:0] dd;
        logic        ecg, edg;
    } vec_t;

    typedef struct {
        logic        port;
        logic [63:0] data;
    } rd_exp_t;

    logic [63:0] ref_mem [256];
    rd_exp_t     sb_q[$];
    logic [7:0]  exp_hold;
    int          n_cmp  = 0;
    int          n_fail = 0;
    vec_t        vecs[17];

    function automatic vec_t mk(input logic cr, input logic cw, input logic [7:0] ca,
                                input logic [63:0] cd, input logic dr, input logic dw,
                                input logic [7:0] da, input logic [63:0] dd,
                                input logic ecg, input logic edg);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.ecg = ecg; v.edg = edg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check and update the model at negedge.
    task automatic step(input vec_t v, input string name);
        rd_exp_t    e;
        logic       exp_crv, exp_drv, exp_wea;
        logic [7:0] exp_addr;
        @(posedge clk);
        #1;
        cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dd;
        @(negedge clk);
        exp_crv = 1'b0;
        exp_drv = 1'b0;
        e.port  = 1'b0;
        e.data  = 64'h0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            exp_crv = (e.port == 1'b0);
            exp_drv = (e.port == 1'b1);
        end
        chk({name, ".cpu_rvalid"}, {63'h0, cpu_rvalid}, {63'h0, exp_crv});
        chk({name, ".dma_rvalid"}, {63'h0, dma_rvalid}, {63'h0, exp_drv});
        if (exp_crv) chk({name, ".cpu_rdata"}, cpu_rdata, e.data);
        if (exp_drv) chk({name, ".dma_rdata"}, dma_rdata, e.data);
        exp_wea  = (v.ecg & v.cw) | (v.edg & v.dw);
        exp_addr = v.ecg ? v.ca : (v.edg ? v.da : exp_hold);
        chk({name, ".cpu_gnt"}, {63'h0, cpu_gnt}, {63'h0, v.ecg});
        chk({name, ".dma_gnt"}, {63'h0, dma_gnt}, {63'h0, v.edg});
        chk({name, ".mem_wea"}, {63'h0, mem_wea}, {63'h0, exp_wea});
        chk({name, ".mem_raddr"}, {56'h0, mem_raddr}, {56'h0, exp_addr});
        chk({name, ".mem_waddr"}, {56'h0, mem_waddr}, {56'h0, exp_addr});
        if (exp_wea) chk({name, ".mem_wdata"}, mem_wdata, v.ecg ? v.cd : v.dd);
        exp_hold = exp_addr;
        if (v.ecg || v.edg) begin
            if (exp_wea) begin
                ref_mem[exp_addr] = v.ecg ? v.cd : v.dd;
            end else begin
                e.port = v.edg;
                e.data = ref_mem[exp_addr];
                sb_q.push_back(e);
            end
        end
    endtask

    vec_t idle_v;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
        idle_v = mk(1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0);
        //           cr    cw    ca     cd                      dr    dw    da     dd                      ecg   edg
        vecs[0]  = idle_v;
        vecs[1]  = mk(1'b1, 1'b1, 8'h10, 64'hDEADBEEF_00000001, 1'b0, 1'b0, 8'h00, 64'h0,                 1'b1, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 8'h10, 64'h0,                 1'b0, 1'b0, 8'h00, 64'h0,                 1'b1, 1'b0);
        vecs[3]  = idle_v;
        vecs[4]  = mk(1'b1, 1'b0, 8'h01, 64'h0,                 1'b0, 1'b0, 8'h00, 64'h0,                 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 8'h00, 64'h0,                 1'b1, 1'b0, 8'h02, 64'h0,                 1'b0, 1'b1);
        vecs[6]  = idle_v;
        vecs[7]  = mk(1'b1, 1'b0, 8'h20, 64'h0,                 1'b1, 1'b0, 8'h30, 64'h0,                 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 8'h21, 64'h0,                 1'b1, 1'b0, 8'h30, 64'h0,                 1'b1, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 8'h22, 64'h0,                 1'b1, 1'b0, 8'h30, 64'h0,                 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 8'h00, 64'h0,                 1'b1, 1'b0, 8'h30, 64'h0,                 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 8'h00, 64'h0,                 1'b1, 1'b1, 8'h40, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
        vecs[12] = mk(1'b1, 1'b0, 8'h40, 64'h0,                 1'b0, 1'b0, 8'h00, 64'h0,                 1'b1, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 8'h50, 64'h5050_5050_0000_0050, 1'b1, 1'b1, 8'h51, 64'h5151_5151_0000_0051, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 8'h00, 64'h0,                 1'b1, 1'b0, 8'h51, 64'h0,                 1'b0, 1'b1);
        vecs[15] = mk(1'b1, 1'b0, 8'h50, 64'h0,                 1'b0, 1'b0, 8'h00, 64'h0,                 1'b1, 1'b0);
        vecs[16] = idle_v;

        // Reset state with both ports requesting.
        rst = 1'b1; mem_clr = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33; cpu_wdata = 64'h0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h44; dma_wdata = 64'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.cpu_gnt",    {63'h0, cpu_gnt},    64'h0);
        chk("rst.dma_gnt",    {63'h0, dma_gnt},    64'h0);
        chk("rst.mem_wea",    {63'h0, mem_wea},    64'h0);
        chk("rst.cpu_rvalid", {63'h0, cpu_rvalid}, 64'h0);
        chk("rst.dma_rvalid", {63'h0, dma_rvalid}, 64'h0);
        chk("rst.cpu_rdata",  cpu_rdata,           64'h0);
        chk("rst.dma_rdata",  dma_rdata,           64'h0);
        chk("rst.mem_raddr",  {56'h0, mem_raddr},  64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; mem_clr = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0;
        exp_hold = 8'h00;

        for (int i = 0; i < 17; i++) step(vecs[i], $sformatf("vec%0d", i));

        // Both ports requesting continuously.
        for (int k = 0; k < 10; k++) begin
            vec_t v;
`ifdef DMEM_ARB_STARVE_EN
            logic fdma = ((k % 5) == 4);
`else
            logic fdma = 1'b0;
`endif
            v = mk(1'b1, 1'b0, 8'(8'h60 + k), 64'h0, 1'b1, 1'b0, 8'(8'h80 + k), 64'h0, ~fdma, fdma);
            step(v, $sformatf("starve%0d", k));
        end
        step(idle_v, "starve_idle");
        step(idle_v, "pre_rst_idle");

        // Reset asserted while a CPU read holds the grant.
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
        #2;
        chk("midrst.gnt_before", {63'h0, cpu_gnt}, 64'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.cpu_gnt", {63'h0, cpu_gnt}, 64'h0);
        chk("midrst.mem_wea", {63'h0, mem_wea}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; cpu_req = 1'b0;
        exp_hold = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d.cpu_rvalid", k), {63'h0, cpu_rvalid}, 64'h0);
            chk($sformatf("postrst%0d.dma_rvalid", k), {63'h0, dma_rvalid}, 64'h0);
            chk($sformatf("postrst%0d.cpu_rdata", k),  cpu_rdata,           64'h0);
        end
        step(mk(1'b1, 1'b0, 8'h03, 64'h0, 1'b1, 1'b0, 8'h04, 64'h0, 1'b1, 1'b0), "postrst_first");
        step(mk(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 8'h04, 64'h0, 1'b0, 1'b1), "postrst_dma");
        step(idle_v, "end_idle0");
        step(idle_v, "end_idle1");
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
